// File: rtl/apb_pkg.sv
// rtl/apb_pkg.sv - shared FSM encoding, APB constants and timeout width helper
package apb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } apb_state_e;

  localparam logic [3:0] APB_PSTRB_ALL     = 4'hF;
  localparam logic [2:0] APB_PPROT_DEFAULT = 3'b000;

  // Counter must be able to hold values 0..to.
  function automatic int tcnt_width(input int to);
    return $clog2(to + 1);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin pick; search starts just after the pointer
module rr_arbiter #(
  parameter int N  = 4,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [N-1:0]  mask,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant
);

  logic [N-1:0]  eligible;
  logic [PW-1:0] idx;
  logic          found;

  always_comb begin
    eligible = req & ~mask;
    grant    = '0;
    found    = 1'b0;
    idx      = '0;
    for (int i = 0; i < N; i++) begin
      idx = PW'((int'(ptr) + 1 + i) % N);
      if (!found && eligible[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/apb_arbiter.sv
// rtl/apb_arbiter.sv - N-requester round-robin APB master with access timeout
module apb_arbiter
  import apb_pkg::*;
#(
  parameter int N   = 4,
  parameter int RW  = 32,
  parameter int RAW = 5,
  parameter int TO  = 16
) (
  input  logic             apb_pclk,
  input  logic             nreset,
  input  logic [N-1:0]     req,
  input  logic [N-1:0]     req_write,
  input  logic [N*RAW-1:0] req_addr,
  input  logic [N*RW-1:0]  req_wdata,
  output logic [N-1:0]     rsp_valid,
  output logic             rsp_err,
  output logic [RW-1:0]    rsp_rdata,
  output logic             apb_psel,
  output logic             apb_penable,
  output logic             apb_pwrite,
  output logic [RAW-1:0]   apb_paddr,
  output logic [RW-1:0]    apb_pwdata,
  output logic [3:0]       apb_pstrb,
  output logic [2:0]       apb_pprot,
  input  logic             apb_pready,
  input  logic [RW-1:0]    apb_prdata
);

  localparam int PW  = $clog2(N);
  localparam int TCW = tcnt_width(TO);
  localparam logic [TCW-1:0] TO_LAST = TCW'(TO - 1);

  apb_state_e     state, state_nxt;
  logic [PW-1:0]  ptr, owner, gnt_idx;
  logic [N-1:0]   grant;
  logic [TCW-1:0] tcnt;
  logic           start, done, timeout;

  assign apb_pstrb = APB_PSTRB_ALL;
  assign apb_pprot = APB_PPROT_DEFAULT;

  // The requester being answered this cycle is masked so it cannot re-win immediately.
  rr_arbiter #(.N(N)) u_rr (
    .req   (req),
    .mask  (rsp_valid),
    .ptr   (ptr),
    .grant (grant)
  );

  always_comb begin
    gnt_idx = '0;
    for (int i = 0; i < N; i++) begin
      if (grant[i]) gnt_idx = PW'(i);
    end
  end

  always_ff @(posedge apb_pclk or negedge nreset) begin
    if (!nreset) state <= ST_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    start       = 1'b0;
    done        = 1'b0;
    timeout     = 1'b0;
    apb_psel    = 1'b0;
    apb_penable = 1'b0;
    case (state)
      ST_IDLE: begin
        if (|grant) begin
          start     = 1'b1;
          state_nxt = ST_SETUP;
        end
      end
      ST_SETUP: begin
        apb_psel  = 1'b1;
        state_nxt = ST_ACCESS;
      end
      ST_ACCESS: begin
        apb_psel    = 1'b1;
        apb_penable = 1'b1;
        if (apb_pready) begin
          done      = 1'b1;
          state_nxt = ST_IDLE;
        end else if (tcnt == TO_LAST) begin
          timeout   = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge apb_pclk or negedge nreset) begin
    if (!nreset) begin
      ptr        <= PW'(N - 1);
      owner      <= '0;
      apb_pwrite <= 1'b0;
      apb_paddr  <= '0;
      apb_pwdata <= '0;
      tcnt       <= '0;
      rsp_valid  <= '0;
      rsp_err    <= 1'b0;
      rsp_rdata  <= '0;
    end else begin
      rsp_valid <= '0;
      if (start) begin
        ptr        <= gnt_idx;
        owner      <= gnt_idx;
        apb_pwrite <= req_write[gnt_idx];
        apb_paddr  <= req_addr[gnt_idx*RAW +: RAW];
        apb_pwdata <= req_wdata[gnt_idx*RW +: RW];
      end
      if (state == ST_SETUP)                      tcnt <= '0;
      else if (state == ST_ACCESS && !apb_pready) tcnt <= tcnt + 1'b1;
      if (done || timeout) begin
        rsp_valid <= {{(N-1){1'b0}}, 1'b1} << owner;
        rsp_err   <= timeout;
        rsp_rdata <= done ? apb_prdata : '0;
      end
    end
  end

endmodule

// File: tb/tb_apb_arbiter.sv
// tb/tb_apb_arbiter.sv - self-checking bench: vector table, directed corners, random vs model
`timescale 1ns/1ps
module tb_apb_arbiter;
  localparam int N = 4, RW = 32, RAW = 5, TO = 16;

  logic             apb_pclk = 1'b0;
  logic             nreset;
  logic [N-1:0]     req, req_write;
  logic [N*RAW-1:0] req_addr;
  logic [N*RW-1:0]  req_wdata;
  logic [N-1:0]     rsp_valid;
  logic             rsp_err;
  logic [RW-1:0]    rsp_rdata;
  logic             apb_psel, apb_penable, apb_pwrite;
  logic [RAW-1:0]   apb_paddr;
  logic [RW-1:0]    apb_pwdata;
  logic [3:0]       apb_pstrb;
  logic [2:0]       apb_pprot;
  logic             apb_pready;
  logic [RW-1:0]    apb_prdata;

  int total = 0, bad = 0;

  apb_arbiter #(.N(N), .RW(RW), .RAW(RAW), .TO(TO)) dut (
    .apb_pclk(apb_pclk), .nreset(nreset), .req(req), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid),
    .rsp_err(rsp_err), .rsp_rdata(rsp_rdata), .apb_psel(apb_psel),
    .apb_penable(apb_penable), .apb_pwrite(apb_pwrite), .apb_paddr(apb_paddr),
    .apb_pwdata(apb_pwdata), .apb_pstrb(apb_pstrb), .apb_pprot(apb_pprot),
    .apb_pready(apb_pready), .apb_prdata(apb_prdata)
  );

  always #5 apb_pclk = ~apb_pclk;

  // Simple memory-backed APB device; initial contents A5A5_0000 + address.
  logic          mem_load;
  logic [RW-1:0] dev_mem [2**RAW];
  assign apb_prdata = dev_mem[apb_paddr];
  always @(posedge apb_pclk) begin
    if (mem_load) begin
      for (int i = 0; i < 2**RAW; i++) dev_mem[i] <= 32'hA5A5_0000 + i;
    end else if (apb_psel && apb_penable && apb_pready && apb_pwrite) begin
      dev_mem[apb_paddr] <= apb_pwdata;
    end
  end

  // Transaction-level reference: who owns the bus, how long it has been there, what it carries.
  int             m_owner, m_last, m_age, m_wait;
  logic           m_wr;
  logic [RAW-1:0] m_addr;
  logic [RW-1:0]  m_wdata;
  logic [N-1:0]   exp_rsp;
  logic           exp_err;
  logic [RW-1:0]  exp_rdata;
  logic [RW-1:0]  m_mem [2**RAW];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_finish(input bit to);
    logic [N-1:0] onehot;
    onehot = '0;
    onehot[m_owner] = 1'b1;
    exp_rsp   = onehot;
    exp_err   = to;
    exp_rdata = to ? '0 : m_mem[m_addr];
    if (!to && m_wr) m_mem[m_addr] = m_wdata;
    m_owner = -1;
  endtask

  task automatic model_step();
    logic [N-1:0] cur_rsp;
    bit           picked;
    cur_rsp = exp_rsp;
    exp_rsp = '0;
    picked  = 0;
    if (!nreset) begin
      m_owner = -1; m_last = N - 1; m_age = 0; m_wait = 0;
      m_wr = 1'b0; m_addr = '0; m_wdata = '0; exp_err = 1'b0; exp_rdata = '0;
    end else if (m_owner < 0) begin
      for (int d = 1; d <= N; d++) begin
        int k;
        k = (m_last + d) % N;
        if (!picked && req[k] && !cur_rsp[k]) begin
          picked  = 1;
          m_owner = k; m_last = k; m_age = 0;
          m_wr    = req_write[k];
          m_addr  = req_addr[k*RAW +: RAW];
          m_wdata = req_wdata[k*RW +: RW];
        end
      end
    end else if (m_age == 0) begin
      m_age = 1; m_wait = 0;
    end else if (apb_pready) begin
      model_finish(0);
    end else begin
      m_wait++;
      if (m_wait == TO) model_finish(1);
    end
  endtask

  task automatic check_outputs();
    chk("psel", apb_psel, m_owner >= 0);
    chk("penable", apb_penable, m_owner >= 0 && m_age == 1);
    chk("rsp_valid", rsp_valid, exp_rsp);
    chk("pstrb", apb_pstrb, 4'hF);
    chk("pprot", apb_pprot, 3'b000);
    if (m_owner >= 0 || !nreset) begin
      chk("paddr", apb_paddr, m_addr);
      chk("pwrite", apb_pwrite, m_wr);
      chk("pwdata", apb_pwdata, m_wdata);
    end
    if (exp_rsp != '0 || !nreset) begin
      chk("rsp_err", rsp_err, exp_err);
      chk("rsp_rdata", rsp_rdata, exp_rdata);
    end
  endtask

  task automatic tick();
    model_step();
    @(negedge apb_pclk);
    check_outputs();
  endtask

  task automatic set_op(input int k, input logic wr, input logic [RAW-1:0] a, input logic [RW-1:0] d);
    req_write[k] = wr;
    req_addr[k*RAW +: RAW] = a;
    req_wdata[k*RW +: RW] = d;
  endtask

  typedef struct {
    int             id;
    logic           wr;
    logic [RAW-1:0] addr;
    logic [RW-1:0]  wdata;
    logic [RW-1:0]  exp_rdata;
  } vec_t;

  vec_t vt[7];
  int   ev_t[$];
  logic [N-1:0] ev_v[$];
  int   lat;

  initial begin
    vt[0] = '{0, 1'b0, 5'd3,  32'h0,         32'hA5A5_0003};
    vt[1] = '{2, 1'b1, 5'd7,  32'h1234_5678, 32'h0};
    vt[2] = '{2, 1'b0, 5'd7,  32'h0,         32'h1234_5678};
    vt[3] = '{1, 1'b0, 5'd31, 32'h0,         32'hA5A5_001F};
    vt[4] = '{3, 1'b1, 5'd0,  32'hDEAD_BEEF, 32'h0};
    vt[5] = '{3, 1'b0, 5'd0,  32'h0,         32'hDEAD_BEEF};
    vt[6] = '{1, 1'b0, 5'd16, 32'h0,         32'hA5A5_0010};

    for (int i = 0; i < 2**RAW; i++) m_mem[i] = 32'hA5A5_0000 + i;
    exp_rsp = '0;
    nreset = 1'b0; mem_load = 1'b1; apb_pready = 1'b1;
    req = '0; req_write = '0; req_addr = '0; req_wdata = '0;
    tick(); tick();
    mem_load = 1'b0; nreset = 1'b1;

    // Table of single transactions on an idle bus with a ready device.
    foreach (vt[i]) begin
      set_op(vt[i].id, vt[i].wr, vt[i].addr, vt[i].wdata);
      req[vt[i].id] = 1'b1;
      tick(); chk("tbl_setup", {apb_psel, apb_penable}, 2'b10);
      tick(); chk("tbl_access", {apb_psel, apb_penable}, 2'b11);
      tick();
      chk("tbl_rsp_valid", rsp_valid, 4'b0001 << vt[i].id);
      chk("tbl_rsp_err", rsp_err, 1'b0);
      if (!vt[i].wr) chk("tbl_rdata", rsp_rdata, vt[i].exp_rdata);
      req[vt[i].id] = 1'b0;
      tick();
    end

    // Reset in the middle of ACCESS aborts without a response.
    set_op(2, 1'b0, 5'd5, 32'h0);
    req[2] = 1'b1; apb_pready = 1'b0;
    tick(); tick(); tick();
    #2 nreset = 1'b0;
    #1;
    chk("async_psel", apb_psel, 1'b0);
    chk("async_penable", apb_penable, 1'b0);
    chk("async_rsp", rsp_valid, 4'b0000);
    req = '0;
    tick(); tick();

    // All four requesting from reset: 0,1,2,3,0 every third cycle.
    for (int k = 0; k < N; k++) set_op(k, 1'b0, RAW'(k + 8), 32'h0);
    req = 4'b1111; apb_pready = 1'b1; nreset = 1'b1;
    for (int t = 1; t <= 15; t++) begin
      tick();
      if (rsp_valid != '0) begin ev_t.push_back(t); ev_v.push_back(rsp_valid); end
    end
    chk("rr_count", ev_t.size(), 5);
    for (int j = 0; j < ev_t.size() && j < 5; j++) begin
      chk("rr_order", ev_v[j], 4'b0001 << (j % 4));
      chk("rr_time", ev_t[j], 3 * (j + 1));
    end
    req = '0;
    for (int t = 0; t < 6; t++) tick();

    // Stalled device times out; pending requester 3 wins in the response cycle.
    set_op(1, 1'b0, 5'd9, 32'h0);
    req[1] = 1'b1; apb_pready = 1'b0;
    tick();
    set_op(3, 1'b0, 5'd12, 32'h0);
    req[3] = 1'b1;
    lat = 0;
    for (int t = 2; t <= 40 && lat == 0; t++) begin
      tick();
      if (rsp_valid != '0) lat = t;
    end
    chk("to_latency", lat, 2 + TO);
    chk("to_rsp_valid", rsp_valid, 4'b0010);
    chk("to_err", rsp_err, 1'b1);
    chk("to_rdata", rsp_rdata, 32'h0);
    tick();
    chk("to_next_setup", {apb_psel, apb_penable}, 2'b10);
    chk("to_next_addr", apb_paddr, 5'd12);
    apb_pready = 1'b1;
    req = '0;
    for (int t = 0; t < 6; t++) tick();

    // Ready arriving on the cycle the count would expire wins over the timeout.
    set_op(0, 1'b0, 5'd4, 32'h0);
    req[0] = 1'b1; apb_pready = 1'b0;
    for (int t = 1; t <= 17; t++) tick();
    apb_pready = 1'b1;
    tick();
    chk("late_ready_valid", rsp_valid, 4'b0001);
    chk("late_ready_err", rsp_err, 1'b0);
    chk("late_ready_rdata", rsp_rdata, 32'hA5A5_0004);
    req = '0;
    for (int t = 0; t < 4; t++) tick();

    // A lone requester holding req is masked in its own response cycle.
    ev_t.delete(); ev_v.delete();
    set_op(1, 1'b0, 5'd2, 32'h0);
    req[1] = 1'b1;
    for (int t = 1; t <= 11; t++) begin
      tick();
      if (rsp_valid != '0) ev_t.push_back(t);
    end
    chk("mask_count", ev_t.size(), 3);
    for (int j = 0; j < ev_t.size() && j < 3; j++) chk("mask_time", ev_t[j], 3 + 4 * j);
    req = '0;
    for (int t = 0; t < 4; t++) tick();

    // Random traffic with random wait states and fields changing while requests are held.
    for (int c = 0; c < 800; c++) begin
      for (int k = 0; k < N; k++) begin
        if (req[k] && rsp_valid[k]) begin
          req[k] = 1'($urandom_range(0, 1));
          set_op(k, 1'($urandom_range(0, 1)), RAW'($urandom), $urandom);
        end else if (!req[k] && $urandom_range(0, 2) == 0) begin
          req[k] = 1'b1;
          set_op(k, 1'($urandom_range(0, 1)), RAW'($urandom), $urandom);
        end else if (req[k] && $urandom_range(0, 7) == 0) begin
          set_op(k, 1'($urandom_range(0, 1)), RAW'($urandom), $urandom);
        end
      end
      apb_pready = ($urandom_range(0, 3) != 0);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/apb_arbiter.md
APB_ARBITER -- requirements
Module: apb_arbiter

Interface
REQ-001 Parameter N, default 4: number of requesters (2..8).
REQ-002 Parameter RW, default 32: data width.
REQ-003 Parameter RAW, default 5: register address width.
REQ-004 Parameter TO, default 16: ACCESS-phase timeout in cycles (1..255).
REQ-005 apb_pclk  in  1  sole clock, all state on rising edge.
REQ-006 nreset  in  1  asynchronous, active-low reset.
REQ-007 req  in  N  per-requester transaction request, held until its rsp_valid bit pulses.
REQ-008 req_write  in  N  per-requester 1=write, 0=read.
REQ-009 req_addr  in  N*RAW  per-requester address, requester i at [i*RAW +: RAW].
REQ-010 req_wdata  in  N*RW  per-requester write data, requester i at [i*RW +: RW].
REQ-011 rsp_valid  out  N  one-hot, single-cycle completion pulse.
REQ-012 rsp_err  out  1  timeout flag, qualified by any rsp_valid bit.
REQ-013 rsp_rdata  out  RW  read data, qualified by rsp_valid.
REQ-014 apb_psel, apb_penable, apb_pwrite  out  1 each  APB master controls.
REQ-015 apb_paddr  out  RAW; apb_pwdata  out  RW; apb_pstrb  out  4; apb_pprot  out  3.
REQ-016 apb_pready  in  1; apb_prdata  in  RW.

Function
REQ-017 FSM states: IDLE, SETUP, ACCESS.
REQ-018 IDLE: if any eligible req, grant winner, latch its write/addr/wdata into registers, go SETUP; otherwise stay in IDLE.
REQ-019 SETUP: apb_psel=1, apb_penable=0, unconditionally go ACCESS next cycle.
REQ-020 ACCESS: apb_psel=1, apb_penable=1; on apb_pready=1 go IDLE.
REQ-021 apb_paddr, apb_pwrite and apb_pwdata come from the latched registers and stay stable through SETUP and ACCESS.
REQ-022 apb_pstrb=4'hF and apb_pprot=3'b000 at all times.
REQ-023 Arbitration is round-robin: search starts at index (last granted + 1) mod N; after reset, requester 0 has highest priority.
REQ-024 Pointer updates only when a grant is issued.
REQ-025 On ACCESS completion, the next cycle (IDLE) has rsp_valid[owner]=1, rsp_rdata=apb_prdata sampled at completion (reads), rsp_err=0.
REQ-026 For writes, rsp_rdata holds the sampled apb_prdata; it is don't-care to requesters.
REQ-027 In the IDLE cycle where rsp_valid[k]=1, requester k is ineligible; all other requesters may be granted in that cycle.
REQ-028 Latency, idle bus, ready device: req high at edge 0 -> SETUP after edge 1 -> ACCESS after edge 2 -> rsp_valid after edge 3; steady-state throughput is one transaction per 3 cycles.
REQ-029 Timeout counter clears on entering ACCESS and increments each ACCESS cycle with apb_pready=0.
REQ-030 When the timeout counter reaches TO: go IDLE, pulse rsp_valid[owner] with rsp_err=1 and rsp_rdata=0.
REQ-031 apb_pready=1 on the same cycle the count reaches TO takes precedence: normal completion, rsp_err=0.
REQ-032 Changes on req or req_* from a granted requester after the grant do not affect the transaction in flight.
REQ-033 A req drop without rsp_valid is a protocol violation; the transaction still completes and rsp_valid still pulses.

Reset
REQ-034 nreset low forces, asynchronously: state=IDLE, apb_psel=0, apb_penable=0, rsp_valid=0, rsp_err=0, rsp_rdata=0, apb_paddr=0, apb_pwdata=0, apb_pwrite=0, RR pointer to N-1 (so requester 0 wins first), timeout count=0.
REQ-035 A reset during SETUP or ACCESS aborts the transaction with no rsp_valid pulse.
REQ-036 Reset release is synchronous to apb_pclk; the first grant is possible at the first rising edge after release.

Structure
REQ-037 Shared package apb_pkg holds the FSM state encoding, the APB_PSTRB_ALL and APB_PPROT_DEFAULT constants, and the timeout counter width derivation.
REQ-038 Round-robin pick is one sub-module, rr_arbiter (N-bit request, N-bit mask, pointer in; one-hot grant out); the FSM stays in apb_arbiter.

Verification
REQ-039 Single read, req[0] with addr 3, device returns 32'hA5A5_0003 -> rsp_valid=4'b0001 three cycles after req, rsp_rdata=32'hA5A5_0003, rsp_err=0.
REQ-040 req=4'b1111 held continuously -> grant order 0,1,2,3,0; each rsp_valid exactly 3 cycles apart.
REQ-041 req[2] write addr 7 data 32'h1234_5678, then read addr 7 -> psel/penable sequence 1/0 then 1/1; read returns 32'h1234_5678.
REQ-042 Device holds apb_pready=0, TO=16 -> after 16 ACCESS cycles, rsp_valid[owner]=1, rsp_err=1, rsp_rdata=0; a pending requester is granted in that same cycle.
REQ-043 nreset asserted during ACCESS -> apb_psel and apb_penable drop immediately with no clock, no rsp_valid pulse; after release, requester 0 wins.
REQ-044 req[1] held after its rsp_valid with req[3] pending -> requester 3 is granted in the rsp_valid cycle, not requester 1.
